uart_sample_loader: RTL and testbench
=====================================

Name: uart_sample_loader

Overview:
- Upstream feeder for the DNN core.
- Receives one training sample over the board UART, at 8N1 and BAUD_RATE.
- A sample is NUM_ACT activation bytes followed by one label byte.
- Presents the sample to the DNN as a flat activation bus plus a one-hot answer vector, using a valid/ready handshake.
- Its done/busy flags drive the "transmission finished" LED.

Parameters:
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD_RATE, 115_200: UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE = 868.
- NUM_ACT, 64: activation bytes per sample. Each activation is 8 bits.
- NUM_ANS, 10: answer classes, i.e. the width of the one-hot answer.

Ports:
- clk  in  1: system clock.
- reset  in  1: asynchronous, active-high reset.
- uart_rx  in  1: serial input, idle high, asynchronous to clk.
- load_start  in  1: single-cycle arm pulse (debounced BTND).
- out_ready  in  1: DNN accepts the presented sample.
- act_out  out  NUM_ACT*8: activations; byte k is at bits [8k+7:8k].
- ans_out  out  NUM_ANS: one-hot label.
- out_valid  out  1: sample complete and stable.
- busy  out  1: armed and receiving.
- frame_err  out  1: sticky; a received byte had a bad stop bit.
- label_err  out  1: sticky; label >= NUM_ANS.
- chk_err  out  1: sticky; checksum mismatch. Tied 0 without the macro.

Behaviour:
- Reset: all outputs 0, act_out and ans_out 0, FSM in IDLE, receiver idle. Reset mid-frame aborts both immediately; no partial sample is retained.
- Receiver synchronisation: uart_rx passes through a 2-FF synchroniser before any use.
- Receiver bit timing:
  - A synced falling edge starts a 434-cycle wait (CLKS_PER_BIT/2).
  - If the line is high at that point, treat it as a false start and return to idle.
  - Otherwise sample the 8 data bits, LSB first, at 868-cycle intervals, then sample the stop bit 868 cycles later.
- Receiver output:
  - Stop bit = 1: emit a 1-cycle byte_valid with the data on the following cycle.
  - Stop bit = 0: set frame_err, emit no byte, return to idle. The receiver keeps looking for a new start edge.
- FSM states are IDLE, RECV_ACT, RECV_ANS, (RECV_CHK), PRESENT.
- IDLE:
  - load_start: clear the byte counter, clear the sticky errors, go to RECV_ACT, busy=1.
  - Bytes arriving in IDLE are discarded.
- RECV_ACT:
  - Each byte_valid writes byte[cnt] and increments cnt.
  - When cnt reaches NUM_ACT-1 and that byte is written, go to RECV_ANS.
- RECV_ANS, on byte_valid:
  - label < NUM_ANS: ans_out = 1<<label.
  - Otherwise: ans_out = 0 and label_err=1; the sample is still presented.
  - Next state is PRESENT, or RECV_CHK when the macro is enabled.
- PRESENT:
  - out_valid=1, busy=0.
  - act_out and ans_out stay stable until the handshake completes.
  - out_valid && out_ready: out_valid=0 next cycle, go to IDLE.
  - Bytes arriving in PRESENT are discarded.
- load_start arriving in RECV_* or PRESENT is ignored. If load_start coincides with the PRESENT handshake cycle, re-arm directly into RECV_ACT.
- While busy, act_out reflects partially written bytes. Consumers sample only while out_valid=1.
- Latency: out_valid rises 1 cycle after the byte_valid of the final byte (label, or checksum when enabled).

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- Enabled:
  - The loader expects one extra byte after the label, equal to the XOR of all NUM_ACT+1 preceding bytes.
  - Match: go to PRESENT.
  - Mismatch: set chk_err, do not present, return to IDLE. The host must re-arm.
- Disabled:
  - No checksum byte is expected and the RECV_CHK state does not exist.
  - chk_err is constant 0.

Decomposition:
- Shared package dnn_io_pkg holds:
  - the FSM state enum;
  - the CLKS_PER_BIT and half-bit constant functions;
  - the one-hot decode function (label to NUM_ANS bits).
- One natural sub-module, uart_rx_byte: synchroniser, bit timer, shift register, byte_valid/frame_err outputs.
- The loader FSM and activation register array stay in uart_sample_loader.

Test Plan:
- Reset mid-stream: assert reset during byte 10 of a sample -> all outputs 0 immediately. After release, a full new sample loads correctly.
- Nominal load:
  - Stimulus: pulse load_start, then send bytes 0x00..0x3F followed by label 0x03.
  - Required: out_valid rises 1 cycle after the last byte_valid; act_out byte k == k; ans_out == 10'b0000001000; busy 0.
- Handshake hold: keep out_ready low for 1000 cycles -> act_out/ans_out unchanged. Pulse out_ready -> out_valid=0 next cycle, state IDLE. Then send 5 bytes without arming -> no state change.
- Errors:
  - Label 0x0C -> ans_out=0, label_err=1, out_valid=1.
  - A byte with stop bit 0 inside the activations -> frame_err=1 and byte count not advanced. The next good byte fills the same index.
- False start: a 200-cycle low glitch on uart_rx -> no byte_valid, counter unchanged.
- Checksum (macro on):
  - Correct XOR byte -> out_valid=1.
  - Corrupt XOR byte (correct value ^ 0x01) -> chk_err=1, out_valid stays 0, FSM in IDLE.

Source files
------------

// File: rtl/dnn_io_pkg.sv
// dnn_io_pkg: shared FSM encodings, UART timing helpers and label decode for the DNN sample loader.
// The RECV_CHK encoding exists only when UART_LOADER_CHECKSUM_EN is defined.
package dnn_io_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_RECV_ACT = 3'd1;
    localparam state_t S_RECV_ANS = 3'd2;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam state_t S_RECV_CHK = 3'd3;
`endif
    localparam state_t S_PRESENT  = 3'd4;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int half_bit(input int clk_freq, input int baud_rate);
        return clks_per_bit(clk_freq, baud_rate) / 2;
    endfunction

    // Callers truncate the result to their own answer width.
    function automatic logic [255:0] label_onehot(input logic [7:0] label, input int num_ans);
        logic [255:0] oh;
        oh = '0;
        if (int'(label) < num_ans) oh[label] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-FF synchroniser, mid-bit sampling and false-start rejection.
module uart_rx_byte
    import dnn_io_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF = half_bit(CLK_FREQ, BAUD_RATE);
    localparam int TW   = $clog2(CPB);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    rs;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign byte_data = shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rs         <= R_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rs)
                R_IDLE: if (rx_prev && !rx_sync) begin
                    rs    <= R_START;
                    timer <= TW'(HALF - 1);
                end
                R_START: if (timer != '0) timer <= timer - 1'b1;
                    else if (rx_sync) rs <= R_IDLE;
                    else begin
                        rs      <= R_DATA;
                        timer   <= TW'(CPB - 1);
                        bit_idx <= '0;
                    end
                R_DATA: if (timer != '0) timer <= timer - 1'b1;
                    else begin
                        shift   <= {rx_sync, shift[7:1]};
                        timer   <= TW'(CPB - 1);
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rs <= R_STOP;
                    end
                default: if (timer != '0) timer <= timer - 1'b1;
                    else begin
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                        rs         <= R_IDLE;
                    end
            endcase
        end
    end

endmodule

// File: rtl/uart_sample_loader.sv
// uart_sample_loader: collects NUM_ACT activation bytes plus a label over UART and presents them to the DNN.
// Define UART_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before presenting.
module uart_sample_loader
    import dnn_io_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int NUM_ACT   = 64,
    parameter int NUM_ANS   = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    input  logic                 load_start,
    input  logic                 out_ready,
    output logic [NUM_ACT*8-1:0] act_out,
    output logic [NUM_ANS-1:0]   ans_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 label_err,
    output logic                 chk_err
);

    localparam int CW = $clog2(NUM_ACT);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    act_mem [NUM_ACT];
    logic          rx_valid, rx_ferr, arm;
    logic [7:0]    rx_data;

    uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (uart_rx),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_ferr)
    );

    for (genvar k = 0; k < NUM_ACT; k++) begin : g_act
        assign act_out[8*k +: 8] = act_mem[k];
    end

    assign out_valid = state == S_PRESENT;
    assign busy      = !(state == S_IDLE || state == S_PRESENT);
    // Arming is honoured in IDLE and also on the PRESENT handshake cycle for back-to-back samples.
    assign arm       = load_start && (state == S_IDLE || (out_valid && out_ready));

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] xor_acc;
    logic       chk_err_q;
    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ans_out   <= '0;
            frame_err <= 1'b0;
            label_err <= 1'b0;
            for (int i = 0; i < NUM_ACT; i++) act_mem[i] <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            xor_acc   <= '0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            if (rx_ferr) frame_err <= 1'b1;
            if (arm) begin
                state     <= S_RECV_ACT;
                cnt       <= '0;
                frame_err <= 1'b0;
                label_err <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
                xor_acc   <= '0;
                chk_err_q <= 1'b0;
`endif
            end else begin
                case (state)
                    S_RECV_ACT: if (rx_valid) begin
                        act_mem[cnt] <= rx_data;
                        cnt          <= cnt + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                        xor_acc      <= xor_acc ^ rx_data;
`endif
                        if (cnt == CW'(NUM_ACT - 1)) state <= S_RECV_ANS;
                    end
                    S_RECV_ANS: if (rx_valid) begin
                        ans_out <= NUM_ANS'(label_onehot(rx_data, NUM_ANS));
                        if (int'(rx_data) >= NUM_ANS) label_err <= 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                        xor_acc <= xor_acc ^ rx_data;
                        state   <= S_RECV_CHK;
`else
                        state   <= S_PRESENT;
`endif
                    end
`ifdef UART_LOADER_CHECKSUM_EN
                    S_RECV_CHK: if (rx_valid) begin
                        if (rx_data == xor_acc) state <= S_PRESENT;
                        else begin
                            chk_err_q <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
`endif
                    S_PRESENT: if (out_ready) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_sample_loader.sv
// tb_uart_sample_loader: randomized UART sample stimulus with a queue scoreboard for presented samples.
// Honours UART_LOADER_CHECKSUM_EN to exercise the checksum byte.
module tb_uart_sample_loader;

    localparam int CLK_FREQ  = 1_200_000;
    localparam int BAUD_RATE = 100_000;
    localparam int CPB       = 12;
    localparam int NUM_ACT   = 64;
    localparam int NUM_ANS   = 10;
    localparam int AW        = NUM_ACT * 8;

    logic              clk = 1'b0, reset = 1'b1, uart_rx = 1'b1, load_start = 1'b0, out_ready = 1'b0;
    logic [AW-1:0]     act_out;
    logic [NUM_ANS-1:0] ans_out;
    logic              out_valid, busy, frame_err, label_err, chk_err;

    uart_sample_loader #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .NUM_ACT(NUM_ACT), .NUM_ANS(NUM_ANS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .load_start (load_start),
        .out_ready  (out_ready),
        .act_out    (act_out),
        .ans_out    (ans_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .label_err  (label_err),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]      act;
        logic [NUM_ANS-1:0] ans;
        logic               lerr;
        logic               ferr;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         errors = 0, checks = 0;
    logic [7:0] acts [NUM_ACT];
    logic       ov_d = 1'b0, bv_d = 1'b0;

    task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && !ov_d) begin
            check("latency_after_last_byte", bv_d, 1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_present: got out_valid=1 expected no sample");
            end else begin
                mon_e = sb.pop_front();
                check("sb_act_out", act_out, mon_e.act);
                check("sb_ans_out", ans_out, mon_e.ans);
                check("sb_label_err", label_err, mon_e.lerr);
                check("sb_frame_err", frame_err, mon_e.ferr);
                check("sb_busy", busy, 0);
            end
        end
        ov_d <= out_valid;
        bv_d <= dut.u_rx.byte_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop;
        tick(CPB);
        uart_rx = 1'b1;
        tick(CPB);
    endtask

    task automatic arm();
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
    endtask

    task automatic randomize_acts();
        for (int i = 0; i < NUM_ACT; i++) acts[i] = 8'($urandom);
    endtask

    // Sends acts[] plus label; optionally a frame-error byte before bad_idx and a glitch before glitch_idx.
    task automatic send_sample(input logic [7:0] label, input int bad_idx, input int glitch_idx, input logic corrupt);
        exp_t       e;
        logic [7:0] xr;
        xr = 8'h00;
        e.act = '0;
        for (int i = 0; i < NUM_ACT; i++) begin
            if (i == glitch_idx) begin
                uart_rx = 1'b0;
                tick(3);
                uart_rx = 1'b1;
                tick(2 * CPB);
            end
            if (i == bad_idx) send_byte(acts[i] ^ 8'hA5, 1'b0);
            send_byte(acts[i], 1'b1);
            xr = xr ^ acts[i];
            e.act[8*i +: 8] = acts[i];
        end
        for (int c = 0; c < NUM_ANS; c++) e.ans[c] = (int'(label) == c);
        e.lerr = int'(label) >= NUM_ANS;
        e.ferr = bad_idx >= 0;
`ifdef UART_LOADER_CHECKSUM_EN
        xr = xr ^ label;
        if (!corrupt) sb.push_back(e);
        send_byte(label, 1'b1);
        send_byte(corrupt ? xr ^ 8'h01 : xr, 1'b1);
`else
        if (!corrupt) sb.push_back(e);
        send_byte(label, 1'b1);
`endif
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 3000) begin
            tick(1);
            n++;
        end
        check("out_valid_timeout", out_valid, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("valid_drop_after_ready", out_valid, 0);
        check("busy_after_ready", busy, 0);
    endtask

    initial begin
        logic [AW-1:0] nom_act;
        tick(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_act_out", act_out, 0);
        check("rst_ans_out", ans_out, 0);
        check("rst_errs", {frame_err, label_err, chk_err}, 0);
        reset = 1'b0;
        tick(2);

        arm();
        check("busy_after_arm", busy, 1);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1), 1'b1);
        check("partial_act_nonzero", act_out[7:0], 8'h01);
        uart_rx = 1'b0;
        tick(5);
        #2 reset = 1'b1;
        #1;
        check("midrst_act_out", act_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        uart_rx = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < NUM_ACT; i++) acts[i] = 8'(i);
        for (int i = 0; i < NUM_ACT; i++) nom_act[8*i +: 8] = 8'(i);
        arm();
        send_sample(8'h03, -1, -1, 1'b0);
        wait_valid();
        tick(1000);
        check("hold_act_out", act_out, nom_act);
        check("hold_ans_out", ans_out, 10'b0000001000);
        check("hold_out_valid", out_valid, 1);
        handshake();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
        check("idle_bytes_valid", out_valid, 0);
        check("idle_bytes_busy", busy, 0);

        randomize_acts();
        arm();
        send_sample(8'h0C, -1, -1, 1'b0);
        wait_valid();
        check("label_err_ans", ans_out, 0);
        handshake();

        randomize_acts();
        arm();
        send_sample(8'($urandom_range(0, 9)), $urandom_range(1, 62), $urandom_range(1, 62), 1'b0);
        wait_valid();
        out_ready  = 1'b1;
        load_start = 1'b1;
        tick(1);
        out_ready  = 1'b0;
        load_start = 1'b0;
        check("rearm_busy", busy, 1);
        check("rearm_valid", out_valid, 0);

        randomize_acts();
        send_sample(8'($urandom_range(0, 9)), -1, -1, 1'b0);
        wait_valid();
        handshake();

`ifdef UART_LOADER_CHECKSUM_EN
        randomize_acts();
        arm();
        send_sample(8'($urandom_range(0, 9)), -1, -1, 1'b1);
        tick(5);
        check("chk_bad_valid", out_valid, 0);
        check("chk_bad_err", chk_err, 1);
        check("chk_bad_busy", busy, 0);
`else
        check("chk_err_tied", chk_err, 0);
`endif
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
